// File: rtl/aes_pkg.sv
// AES shared constants: block/byte widths and S-box tables.
// Inverse table built only when AES_SUB_BYTES_INV_EN is defined.
package aes_pkg;

  localparam int AES_BLOCK_W = 128;
  localparam int AES_BYTE_W  = 8;
  localparam int AES_NBYTES  = AES_BLOCK_W / AES_BYTE_W;

  localparam logic [7:0] SBOX_FWD [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

`ifdef AES_SUB_BYTES_INV_EN
  localparam logic [7:0] SBOX_INV [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
    8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
    8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
    8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
    8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
    8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
    8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
    8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
    8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
    8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
    8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
    8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
    8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
    8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
    8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
    8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
    8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };
`endif

endpackage

// File: rtl/aes_sbox.sv
// Single-byte AES S-box lookup, purely combinational.
// Ports: raw (byte to substitute), sub (result), inv (inverse
// select, only with AES_SUB_BYTES_INV_EN defined).
module aes_sbox
  import aes_pkg::*;
(
`ifdef AES_SUB_BYTES_INV_EN
  input  logic                  inv,
`endif
  input  logic [AES_BYTE_W-1:0] raw,
  output logic [AES_BYTE_W-1:0] sub
);

`ifdef AES_SUB_BYTES_INV_EN
  always_comb begin
    sub = SBOX_FWD[raw];
    if (inv) sub = SBOX_INV[raw];
  end
`else
  assign sub = SBOX_FWD[raw];
`endif

endmodule

// File: rtl/aes_sub_bytes.sv
// AES SubBytes round stage: 16 parallel S-boxes, 1-cycle registered.
// Ports: i_clk, i_rst (sync, active-high), i_aes_sub_bytes_valid,
// i_aes_sub_bytes_data_in[127:0], o_aes_sub_bytes_valid,
// o_aes_sub_bytes_s_data_out[127:0]; i_aes_sub_bytes_inv only with
// AES_SUB_BYTES_INV_EN defined (selects inverse S-box per transfer).
module aes_sub_bytes
  import aes_pkg::*;
(
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_aes_sub_bytes_valid,
`ifdef AES_SUB_BYTES_INV_EN
  input  logic                   i_aes_sub_bytes_inv,
`endif
  input  logic [AES_BLOCK_W-1:0] i_aes_sub_bytes_data_in,
  output logic                   o_aes_sub_bytes_valid,
  output logic [AES_BLOCK_W-1:0] o_aes_sub_bytes_s_data_out
);

  logic [AES_BLOCK_W-1:0] sub;
  logic                   valid_q;
  logic [AES_BLOCK_W-1:0] data_q;

  for (genvar k = 0; k < AES_NBYTES; k++) begin : g_byte
    aes_sbox u_sbox (
`ifdef AES_SUB_BYTES_INV_EN
      .inv (i_aes_sub_bytes_inv),
`endif
      .raw (i_aes_sub_bytes_data_in[AES_BYTE_W*k +: AES_BYTE_W]),
      .sub (sub[AES_BYTE_W*k +: AES_BYTE_W])
    );
  end

  // Data holds across idle cycles; only valid drops.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= i_aes_sub_bytes_valid;
      if (i_aes_sub_bytes_valid) data_q <= sub;
    end
  end

  assign o_aes_sub_bytes_valid      = valid_q;
  assign o_aes_sub_bytes_s_data_out = data_q;

endmodule

// File: tb/tb_aes_sub_bytes.sv
// Self-checking bench for aes_sub_bytes: directed vector table plus
// hand sequences for reset, back-to-back, hold and inverse mode.
module tb_aes_sub_bytes;

  logic         clk;
  logic         rst;
  logic         vin;
  logic         inv;
  logic [127:0] din;
  logic         vout;
  logic [127:0] dout;

  int total = 0;
  int bad   = 0;

  aes_sub_bytes dut (
    .i_clk                      (clk),
    .i_rst                      (rst),
    .i_aes_sub_bytes_valid      (vin),
`ifdef AES_SUB_BYTES_INV_EN
    .i_aes_sub_bytes_inv        (inv),
`endif
    .i_aes_sub_bytes_data_in    (din),
    .o_aes_sub_bytes_valid      (vout),
    .o_aes_sub_bytes_s_data_out (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [127:0] din;
    logic [127:0] exp;
  } vec_t;

  localparam logic [127:0] V1_IN  = 128'h193de3be_a0f4e22b_9ac68d2a_e9f84808;
  localparam logic [127:0] V1_OUT = 128'hd42711ae_e0bf98f1_b8b45de5_1e415230;
  localparam logic [127:0] V2_IN  = 128'hffeeddcc_bbaa9988_77665544_33221100;
  localparam logic [127:0] V2_OUT = 128'h1628c14b_eaaceec4_f533fc1b_c3938263;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Advance one edge, then settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t tbl [5];

  initial begin
    tbl[0] = '{"vec1", V1_IN, V1_OUT};
    tbl[1] = '{"vec2", V2_IN, V2_OUT};
    tbl[2] = '{"zeros", 128'h0, {16{8'h63}}};
    tbl[3] = '{"ones", {16{8'hff}}, {16{8'h16}}};
    tbl[4] = '{"row0", 128'h00010203_04050607_08090a0b_0c0d0e0f,
               128'h637c777b_f26b6fc5_3001672b_fed7ab76};

    rst = 1'b1;
    vin = 1'b1;
    inv = 1'b0;
    din = V1_IN;

    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_valid", {127'h0, vout}, 128'h0);
      chk("rst_data", dout, 128'h0);
    end

    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      vin = 1'b1;
      din = tbl[i].din;
      step();
      chk({tbl[i].name, "_valid"}, {127'h0, vout}, 128'h1);
      chk(tbl[i].name, dout, tbl[i].exp);
    end

    // Back-to-back then idle: data must hold the last result.
    vin = 1'b1;
    din = V1_IN;
    step();
    chk("b2b1_valid", {127'h0, vout}, 128'h1);
    chk("b2b1_data", dout, V1_OUT);
    din = V2_IN;
    step();
    chk("b2b2_valid", {127'h0, vout}, 128'h1);
    chk("b2b2_data", dout, V2_OUT);
    vin = 1'b0;
    din = 128'h0;
    step();
    chk("idle_valid", {127'h0, vout}, 128'h0);
    chk("hold_data", dout, V2_OUT);
    step();
    chk("hold2_data", dout, V2_OUT);

    // Reset mid-stream wins over a valid transfer.
    vin = 1'b1;
    din = {16{8'hff}};
    step();
    chk("pre_rst_data", dout, {16{8'h16}});
    rst = 1'b1;
    din = V1_IN;
    step();
    chk("mid_rst_valid", {127'h0, vout}, 128'h0);
    chk("mid_rst_data", dout, 128'h0);
    rst = 1'b0;
    vin = 1'b0;
    step();
    chk("post_rst_valid", {127'h0, vout}, 128'h0);
    chk("post_rst_data", dout, 128'h0);

`ifdef AES_SUB_BYTES_INV_EN
    vin = 1'b1;
    inv = 1'b1;
    din = V1_OUT;
    step();
    chk("inv_vec1", dout, V1_IN);
    din = {16{8'h63}};
    step();
    chk("inv_63", dout, 128'h0);
    for (int i = 0; i < 4; i++) begin
      logic [127:0] orig;
      orig = {$urandom, $urandom, $urandom, $urandom};
      inv = 1'b0;
      din = orig;
      step();
      inv = 1'b1;
      din = dout;
      step();
      chk("round_trip", dout, orig);
    end
    vin = 1'b0;
    inv = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
